// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with fixed wait states,
// byte-lane merge on stores and sign/zero extension on loads. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
    stateT state, nextState;
    logic [63:0] mem [DEPTH_WORDS];
    logic [3:0]  waitCnt;
    logic        capWrite, capUnsigned;
    logic [63:0] capAddr, capWdata;
    logic [1:0]  capSize;
    logic        accept, execute, outOfRange, misalign, accessErr, signExt;
    logic [2:0]  lane, lowMask, effLane;
    logic [5:0]  shamt;
    logic [AW-1:0] wordIdx;
    logic [63:0] oldWord, sizeMask, mergedWord, shifted, loadVal;

    assign req_ready = state == IDLE && !reset;
    assign accept    = req_valid && req_ready;
    assign execute   = state == WAIT && waitCnt == 4'd0;

    always_comb begin
        nextState = state;
        nextState = accept ? WAIT :
                    execute ? RESP :
                    (state == RESP && resp_ready) ? IDLE : state;
    end

    assign lane       = capAddr[2:0];
    assign lowMask    = {capSize == 2'd3, capSize[1], capSize != 2'd0};
    assign outOfRange = capAddr[63:3] >= 61'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
    // Naturally aligned power-of-two accesses can never straddle the 8-byte word.
    assign misalign = (lane & lowMask) != 3'd0;
    assign effLane  = lane;
`else
    assign misalign = 1'b0;
    assign effLane  = lane & ~lowMask;
`endif
    assign accessErr = outOfRange || misalign;
    assign wordIdx   = capAddr[3 +: AW];
    assign oldWord   = mem[wordIdx];
    assign shamt     = {effLane, 3'b000};
    assign signExt   = !capUnsigned;

    always_comb begin
        sizeMask   = capSize == 2'd3 ? 64'hFFFF_FFFF_FFFF_FFFF :
                     capSize == 2'd2 ? 64'h0000_0000_FFFF_FFFF :
                     capSize == 2'd1 ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_0000_00FF;
        mergedWord = (oldWord & ~(sizeMask << shamt)) | ((capWdata & sizeMask) << shamt);
        shifted    = oldWord >> shamt;
        loadVal    = capSize == 2'd0 ? {{56{signExt && shifted[7]}}, shifted[7:0]} :
                     capSize == 2'd1 ? {{48{signExt && shifted[15]}}, shifted[15:0]} :
                     capSize == 2'd2 ? {{32{signExt && shifted[31]}}, shifted[31:0]} : shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            capWrite    <= req_write;
            capAddr     <= req_addr;
            capSize     <= req_size;
            capUnsigned <= req_unsigned;
            capWdata    <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt    <= 4'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) waitCnt <= 4'(LATENCY - 1);
            else if (state == WAIT && waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
            if (execute) begin
                resp_valid <= 1'b1;
                resp_err   <= accessErr;
                resp_rdata <= (accessErr || capWrite) ? 64'd0 : loadVal;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                resp_err   <= 1'b0;
                resp_rdata <= 64'd0;
            end
        end
    end

    // Storage has no reset; a reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (execute && capWrite && !accessErr && !reset) mem[wordIdx] <= mergedWord;
    end
endmodule
